// File: rtl/narvie_pkg.sv
// narvie_pkg
// Shared definitions for the instruction execution sequencer:
//   seq_state_t - FSM state encoding used by exec_sequencer
//   NOOP_INSTR  - default instruction presented to the CPU outside EXEC
//   WORD_W      - instruction word width
//   CNT_W       - width of the EXEC cycle counter and the ack timeout counter
package narvie_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } seq_state_t;

    localparam int              WORD_W     = 32;
    localparam int              CNT_W      = 16;
    localparam logic [WORD_W-1:0] NOOP_INSTR = 32'h00000013;

endpackage

// File: rtl/instr_pending_buf.sv
// instr_pending_buf
// One-entry holding slot for instructions that arrive while the sequencer
// cannot start them immediately, plus the sticky overflow flag.
// Ports:
//   clk12, rst   - clock, async active-high reset
//   instr_valid  - one-cycle strobe, instr_in holds a word
//   instr_in     - received instruction word
//   in_idle      - sequencer is in IDLE this cycle
//   consume      - sequencer takes the held word this cycle
//   pend_valid   - slot holds a word
//   pend_word    - held word
//   overflow     - sticky: a word arrived while the slot was full
module instr_pending_buf
    import narvie_pkg::*;
(
    input  logic              clk12,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [WORD_W-1:0] instr_in,
    input  logic              in_idle,
    input  logic              consume,
    output logic              pend_valid,
    output logic [WORD_W-1:0] pend_word,
    output logic              overflow
);

    // The slot is freed in the same cycle it is consumed, so a word arriving
    // alongside a consume refills it. In IDLE with an empty slot the word goes
    // straight to EXEC and is not stored.
    logic drop;
    logic fill;

    assign drop = instr_valid && pend_valid && !consume;
    assign fill = instr_valid && !drop && (!in_idle || consume);

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_word  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (fill) begin
                pend_valid <= 1'b1;
                pend_word  <= instr_in;
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer
// Presents one received instruction to the CPU, clocks the CPU for a fixed
// number of cycles, requests a regfile dump and waits for the transmitter
// handshake (bounded by a timeout) before accepting the next instruction.
// Ports:
//   clk12        - sole clock
//   rst          - async active-high reset
//   instr_valid  - one-cycle strobe, instr_in holds a word
//   instr_in     - received instruction word
//   tx_ready     - regfile transmitter idle (1) / busy (0)
//   proc_clk     - registered processor clock, 1 when not executing
//   inst_to_cpu  - registered instruction word for the CPU
//   send_regfile - one-cycle regfile dump request
//   busy         - state is not IDLE
//   overflow     - sticky: an instruction was dropped
//   tx_timeout   - sticky: the transmitter handshake timed out
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a pending or newly received instruction
// EXEC      | CPU clocked for EXEC_CYCLES cycles with the latched word
// SEND      | one-cycle regfile dump request
// WAIT_BUSY | waiting for the transmitter to go busy (tx_ready=0)
// WAIT_DONE | waiting for the transmitter to finish (tx_ready=1)
module exec_sequencer
    import narvie_pkg::*;
#(
    parameter int                EXEC_CYCLES = 10,
    parameter logic [WORD_W-1:0] NOOP        = NOOP_INSTR,
    parameter int                ACK_TIMEOUT = 255
) (
    input  logic              clk12,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [WORD_W-1:0] instr_in,
    input  logic              tx_ready,
    output logic              proc_clk,
    output logic [WORD_W-1:0] inst_to_cpu,
    output logic              send_regfile,
    output logic              busy,
    output logic              overflow,
    output logic              tx_timeout
);

    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(ACK_TIMEOUT - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              pend_valid;
    logic [WORD_W-1:0] pend_word;
    logic              consume;
    logic              exec_start;
    logic [WORD_W-1:0] exec_word;
    logic              exec_last;
    logic              tmo_expired;
    logic              timeout_hit;

    assign exec_last   = (cycle_cnt == EXEC_LAST);
    assign tmo_expired = (tmo_cnt == '0);

    instr_pending_buf u_pending (
        .clk12       (clk12),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .in_idle     (state == ST_IDLE),
        .consume     (consume),
        .pend_valid  (pend_valid),
        .pend_word   (pend_word),
        .overflow    (overflow)
    );

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        consume     = 1'b0;
        exec_start  = 1'b0;
        exec_word   = NOOP;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                // A held word is older than one arriving now, so it goes first.
                if (pend_valid) begin
                    consume    = 1'b1;
                    exec_start = 1'b1;
                    exec_word  = pend_word;
                    state_next = ST_EXEC;
                end else if (instr_valid) begin
                    exec_start = 1'b1;
                    exec_word  = instr_in;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_last) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end else if (!tx_ready) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A completion in the final allowed cycle is not a timeout.
                if (tx_ready) begin
                    state_next = ST_IDLE;
                end else if (tmo_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            proc_clk    <= 1'b1;
            inst_to_cpu <= NOOP;
        end else if (exec_start) begin
            cycle_cnt   <= '0;
            proc_clk    <= 1'b0;
            inst_to_cpu <= exec_word;
        end else if (state == ST_EXEC) begin
            if (exec_last) begin
                cycle_cnt   <= '0;
                proc_clk    <= 1'b1;
                inst_to_cpu <= NOOP;
            end else begin
                cycle_cnt <= cycle_cnt + 1'b1;
                proc_clk  <= ~proc_clk;
            end
        end
    end

    // One budget spans both wait states: loaded in SEND, counted down to zero.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_SEND) begin
            tmo_cnt <= TMO_LOAD;
        end else if ((state == ST_WAIT_BUSY || state == ST_WAIT_DONE) && !tmo_expired) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            tx_timeout <= 1'b0;
        end else if (timeout_hit) begin
            tx_timeout <= 1'b1;
        end
    end

    assign send_regfile = (state == ST_SEND);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer
// Directed bench for exec_sequencer with default parameters
// (EXEC_CYCLES=10, NOOP=32'h00000013, ACK_TIMEOUT=255).
module tb_exec_sequencer;

    logic        clk12;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        tx_ready;
    logic        proc_clk;
    logic [31:0] inst_to_cpu;
    logic        send_regfile;
    logic        busy;
    logic        overflow;
    logic        tx_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP_W = 32'h00000013;

    exec_sequencer dut (
        .clk12        (clk12),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_in     (instr_in),
        .tx_ready     (tx_ready),
        .proc_clk     (proc_clk),
        .inst_to_cpu  (inst_to_cpu),
        .send_regfile (send_regfile),
        .busy         (busy),
        .overflow     (overflow),
        .tx_timeout   (tx_timeout)
    );

    initial clk12 = 1'b0;
    always #5 clk12 = ~clk12;

    task automatic cyc();
        @(posedge clk12);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at the first EXEC sample; returns at the first IDLE sample.
    task automatic run_to_idle();
        repeat (10) cyc();
        tx_ready = 1'b0;
        cyc();
        cyc();
        tx_ready = 1'b1;
        cyc();
    endtask

    initial begin : stim
        logic prev_pc;
        int   rises;
        int   bad;
        int   n;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_in    = '0;
        tx_ready    = 1'b1;
        repeat (3) cyc();

        // reset values
        chk1 ("rst_proc_clk", proc_clk, 1'b1);
        chk32("rst_inst", inst_to_cpu, NOP_W);
        chk1 ("rst_send", send_regfile, 1'b0);
        chk1 ("rst_busy", busy, 1'b0);
        chk1 ("rst_overflow", overflow, 1'b0);
        chk1 ("rst_tx_timeout", tx_timeout, 1'b0);
        rst = 1'b0;
        cyc();

        // idle check, then timeout since tx_ready never drops
        instr_valid = 1'b1;
        instr_in    = 32'h00500093;
        cyc();
        instr_valid = 1'b0;
        prev_pc = 1'b1;
        rises   = 0;
        bad     = 0;
        for (int i = 0; i < 10; i++) begin
            if (inst_to_cpu !== 32'h00500093 || send_regfile !== 1'b0 || busy !== 1'b1) bad++;
            if (!prev_pc && proc_clk) rises++;
            prev_pc = proc_clk;
            cyc();
        end
        chkint("exec_inst_hold", bad, 0);
        chkint("exec_rising_edges", rises, 5);
        chk1 ("exec_last_proc_clk", prev_pc, 1'b1);
        chk1 ("send_pulse", send_regfile, 1'b1);
        chk32("send_inst_noop", inst_to_cpu, NOP_W);
        chk1 ("send_proc_clk", proc_clk, 1'b1);
        chk1 ("send_no_timeout", tx_timeout, 1'b0);
        cyc();
        chk1 ("send_one_cycle", send_regfile, 1'b0);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            cyc();
        end
        chkint("timeout_wait_cycles", n, 255);
        chk1 ("timeout_flag", tx_timeout, 1'b1);
        chk1 ("timeout_no_overflow", overflow, 1'b0);

        // normal handshake: tx_ready low for 20 cycles after SEND
        instr_valid = 1'b1;
        instr_in    = 32'h00100113;
        cyc();
        instr_valid = 1'b0;
        repeat (10) cyc();
        chk1("hs_send", send_regfile, 1'b1);
        tx_ready = 1'b0;
        repeat (20) cyc();
        tx_ready = 1'b1;
        chk1("hs_busy_before", busy, 1'b1);
        cyc();
        chk1("hs_busy_after", busy, 1'b0);
        chk1("hs_timeout_sticky", tx_timeout, 1'b1);

        // instr_valid coincident with WAIT_DONE completion
        instr_valid = 1'b1;
        instr_in    = 32'h00200193;
        cyc();
        instr_valid = 1'b0;
        repeat (10) cyc();
        tx_ready = 1'b0;
        cyc();
        cyc();
        tx_ready    = 1'b1;
        instr_valid = 1'b1;
        instr_in    = 32'h00300213;
        cyc();
        instr_valid = 1'b0;
        chk1 ("sim_idle_busy", busy, 1'b0);
        chk32("sim_idle_inst", inst_to_cpu, NOP_W);
        cyc();
        chk32("sim_exec_inst", inst_to_cpu, 32'h00300213);
        chk1 ("sim_exec_proc_clk", proc_clk, 1'b0);
        chk1 ("sim_no_overflow", overflow, 1'b0);
        run_to_idle();
        chk1("sim_back_idle", busy, 1'b0);

        // pending and overflow: A executes, B follows, C dropped
        instr_valid = 1'b1;
        instr_in    = 32'h00A00093;
        cyc();
        instr_valid = 1'b0;
        cyc();
        instr_valid = 1'b1;
        instr_in    = 32'h00B00093;
        cyc();
        instr_valid = 1'b0;
        cyc();
        instr_valid = 1'b1;
        instr_in    = 32'h00C00093;
        cyc();
        instr_valid = 1'b0;
        chk1 ("ovf_flag", overflow, 1'b1);
        chk32("ovf_a_running", inst_to_cpu, 32'h00A00093);
        repeat (6) cyc();
        chk1("ovf_a_send", send_regfile, 1'b1);
        tx_ready = 1'b0;
        cyc();
        cyc();
        tx_ready = 1'b1;
        cyc();
        chk1("ovf_idle_between", busy, 1'b0);
        cyc();
        chk32("ovf_b_runs", inst_to_cpu, 32'h00B00093);
        chk1 ("ovf_b_proc_clk", proc_clk, 1'b0);
        run_to_idle();
        cyc();
        chk1 ("ovf_c_dropped", busy, 1'b0);
        chk32("ovf_c_noop", inst_to_cpu, NOP_W);

        // reset mid-EXEC with a word held in the pending slot
        instr_valid = 1'b1;
        instr_in    = 32'h00D00093;
        cyc();
        instr_in    = 32'h00E00093;
        cyc();
        instr_valid = 1'b0;
        cyc();
        chk1("rx_pre_proc_clk", proc_clk, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk1 ("rx_proc_clk_async", proc_clk, 1'b1);
        chk32("rx_inst", inst_to_cpu, NOP_W);
        chk1 ("rx_busy", busy, 1'b0);
        chk1 ("rx_overflow", overflow, 1'b0);
        chk1 ("rx_tx_timeout", tx_timeout, 1'b0);
        chk1 ("rx_send", send_regfile, 1'b0);
        bad = 0;
        repeat (3) begin
            cyc();
            if (proc_clk !== 1'b1) bad++;
        end
        chkint("rx_proc_clk_held", bad, 0);
        rst = 1'b0;
        cyc();
        cyc();
        chk1("rx_pending_cleared", busy, 1'b0);
        instr_valid = 1'b1;
        instr_in    = 32'h00F00093;
        cyc();
        instr_valid = 1'b0;
        chk32("rx_new_inst", inst_to_cpu, 32'h00F00093);
        chk1 ("rx_new_proc_clk", proc_clk, 1'b0);
        repeat (10) cyc();
        chk1("rx_new_send", send_regfile, 1'b1);
        tx_ready = 1'b0;
        cyc();
        cyc();
        tx_ready = 1'b1;
        cyc();
        chk1("rx_new_idle", busy, 1'b0);
        chk1("rx_new_no_timeout", tx_timeout, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter EXEC_CYCLES, default 10, SHALL set the clk12 cycles spent in EXEC; legal values are even and 2..65534.
REQ-002 Parameter NOOP, default 32'h00000013, SHALL be the instruction presented to the CPU outside EXEC.
REQ-003 Parameter ACK_TIMEOUT, default 255, SHALL set the maximum clk12 cycles spent in WAIT_TX.
REQ-004 clk12  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 instr_valid  in  1  one-cycle pulse: instr_in holds a received instruction.
REQ-007 instr_in  in  32  received instruction word.
REQ-008 tx_ready  in  1  regfile transmitter idle (1) / busy (0).
REQ-009 proc_clk  out  1  registered processor clock; held 1 when not executing.
REQ-010 inst_to_cpu  out  32  registered instruction word for the CPU.
REQ-011 send_regfile  out  1  one-cycle pulse requesting a regfile dump.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 overflow  out  1  sticky flag: an instruction was dropped.
REQ-014 tx_timeout  out  1  sticky flag: WAIT_TX expired.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, SEND, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE SHALL go to EXEC on the next edge if the pending slot is valid (pending consumed first) or instr_valid=1; if both, instr_in SHALL fill pending.
REQ-017 On entry to EXEC, the selected word SHALL be latched into inst_to_cpu, the cycle counter cleared and proc_clk driven 0.
REQ-018 In EXEC, proc_clk SHALL toggle every clk12 cycle.
REQ-019 EXEC SHALL last exactly EXEC_CYCLES cycles, giving EXEC_CYCLES/2 proc_clk rising edges and proc_clk=1 in the last EXEC cycle.
REQ-020 EXEC SHALL then go to SEND.
REQ-021 SEND SHALL last one cycle with send_regfile=1, then go to WAIT_BUSY.
REQ-022 send_regfile SHALL be 0 in every other state.
REQ-023 WAIT_BUSY SHALL go to WAIT_DONE when tx_ready=0.
REQ-024 WAIT_DONE SHALL go to IDLE when tx_ready=1.
REQ-025 A shared timeout counter SHALL run across both wait states; if ACK_TIMEOUT cycles pass without reaching IDLE, the FSM SHALL go to IDLE and set tx_timeout.
REQ-026 Outside EXEC, proc_clk SHALL be 1 and inst_to_cpu SHALL be NOOP, starting from the first cycle after leaving EXEC.
REQ-027 A one-entry pending slot SHALL capture instr_valid whenever state is not IDLE and the slot is empty.
REQ-028 instr_valid while the slot is full SHALL drop the word and set overflow; this applies in any state.
REQ-029 instr_valid in the same cycle that WAIT_DONE completes SHALL fill pending; EXEC SHALL begin two cycles later.
REQ-030 The cycle counter SHALL be 16-bit and saturate-free; it SHALL only be compared for equality with EXEC_CYCLES-1.
REQ-031 overflow and tx_timeout SHALL be cleared only by rst.

Reset
REQ-032 While rst=1, state SHALL be IDLE, with proc_clk=1, inst_to_cpu=NOOP, send_regfile=0, busy=0, overflow=0, tx_timeout=0, pending cleared and counters 0.
REQ-033 Assertion of rst mid-EXEC SHALL force proc_clk to 1 asynchronously, with no further proc_clk edges.
REQ-034 After rst deasserts, the first instr_valid SHALL be honoured.

Structure
REQ-035 State encodings and the default NOOP SHALL live in the shared narvie package/header used by the top level.
REQ-036 The pending slot and overflow logic SHALL be one sub-module, instr_pending_buf.
REQ-037 The FSM, counters and output registers SHALL live in exec_sequencer.

Verification
REQ-038 Idle check: pulse instr_valid with instr_in=32'h00500093 while tx_ready=1 -> inst_to_cpu=32'h00500093 for 10 cycles, exactly 5 proc_clk rising edges, send_regfile pulses once, then inst_to_cpu=32'h00000013.
REQ-039 Normal handshake: after SEND, tx_ready=0 for 20 cycles then 1 -> busy falls one cycle after tx_ready rises.
REQ-040 Pending and overflow: three instr_valid pulses during EXEC (A, B, C) -> A executes, B executes next, C is dropped, overflow=1.
REQ-041 Timeout: tx_ready held 1 after SEND (never drops) -> return to IDLE after 255 cycles, tx_timeout=1.
REQ-042 Reset mid-EXEC: assert rst at EXEC cycle 3 -> proc_clk=1 immediately, inst_to_cpu=NOOP, all flags 0; a new instr_valid executes normally.
REQ-043 Simultaneous events: instr_valid coincident with WAIT_DONE completion -> that word executes with EXEC starting 2 cycles later; overflow stays 0.
